ttt_move_arbiter: RTL and testbench

Turn sequencer between the nine cell push-buttons and the tic-tac-toe board datapath. It synchronizes and edge-detects the buttons, picks one legal press per turn, and presents it to the datapath over a valid/ready handshake. It tracks whose turn it is, blocks repeat presses until all buttons are released, and runs the start/game-over cycle. An optional per-turn move timer forfeits a stalled turn.

---
 rtl/ttt_pkg.sv | 25 ++
 rtl/ttt_move_arbiter_btn_sync.sv | 30 +++
 rtl/ttt_move_arbiter.sv | 136 +++++++++++++
 tb/tb_ttt_move_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and constants for the tic-tac-toe move arbiter
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    typedef logic [3:0] cell_idx_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ISSUE,
        RELEASE,
        DONE
    } arb_state_t;

    function automatic cell_idx_t lowest_cell(input logic [NUM_CELLS-1:0] v);
        lowest_cell = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--)
            if (v[i]) lowest_cell = cell_idx_t'(i);
    endfunction

endpackage

// File: rtl/ttt_move_arbiter_btn_sync.sv
// btn_sync: multi-flop synchronizer per bit with a one-cycle rising-edge output
module btn_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;

    // shift raw inputs through the chain; prev holds last cycle's synchronized value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;

endmodule

// File: rtl/ttt_move_arbiter.sv
// ttt_move_arbiter: turn sequencer from cell buttons to board datapath; TTT_TURN_TIMER_EN adds a per-turn forfeit timer
module ttt_move_arbiter
    import ttt_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CELLS-1:0] buttons,
    input  logic [NUM_CELLS-1:0] occupied,
    input  logic                 start,
    input  logic                 finished,
    input  logic                 move_ready,
    output logic                 move_valid,
    output logic [3:0]           move_cell,
    output logic                 move_player,
    output logic                 curr_player,
    output logic                 illegal_press,
    output logic                 turn_timeout,
    output logic                 new_game
);

    arb_state_t           state, state_n;
    logic [NUM_CELLS-1:0] sync, rise, cand;
    cell_idx_t            cell_n;
    logic                 mp_n, cp_n, ill_n;

    btn_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(NUM_CELLS)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (buttons),
        .sync    (sync),
        .rise    (rise)
    );

    assign cand = rise & ~occupied;

`ifdef TTT_TURN_TIMER_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmr, tmr_n;
    logic          to_n;
`endif

    // next-state, latched move and turn bookkeeping; finished pre-empts ARMED and RELEASE
    always_comb begin
        state_n = state;
        cell_n  = move_cell;
        mp_n    = move_player;
        cp_n    = curr_player;
        ill_n   = 1'b0;
`ifdef TTT_TURN_TIMER_EN
        tmr_n   = '0;
        to_n    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ARMED;
                    cp_n    = P1;
                end
            end
            ARMED: begin
                if (finished) begin
                    state_n = DONE;
                end else if (|cand) begin
                    state_n = ISSUE;
                    cell_n  = lowest_cell(cand);
                    mp_n    = curr_player;
                end else begin
                    ill_n = |(rise & occupied);
`ifdef TTT_TURN_TIMER_EN
                    if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                        to_n = 1'b1;
                        cp_n = ~curr_player;
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
`endif
                end
            end
            ISSUE: begin
                if (move_ready) begin
                    cp_n    = ~curr_player;
                    state_n = finished ? DONE : RELEASE;
                end
            end
            RELEASE: begin
                state_n = finished ? DONE : (|sync ? RELEASE : ARMED);
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // state and registered outputs; valid/new_game decode the next state so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            move_valid    <= 1'b0;
            move_cell     <= '0;
            move_player   <= 1'b0;
            curr_player   <= 1'b0;
            illegal_press <= 1'b0;
            new_game      <= 1'b0;
        end else begin
            state         <= state_n;
            move_valid    <= (state_n == ISSUE);
            move_cell     <= cell_n;
            move_player   <= mp_n;
            curr_player   <= cp_n;
            illegal_press <= ill_n;
            new_game      <= (state_n == DONE);
        end
    end

`ifdef TTT_TURN_TIMER_EN
    // turn timer runs only in ARMED and is zero on every entry to it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr          <= '0;
            turn_timeout <= 1'b0;
        end else begin
            tmr          <= tmr_n;
            turn_timeout <= to_n;
        end
    end
`else
    assign turn_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_move_arbiter.sv
// tb_ttt_move_arbiter: directed vector table plus hand sequences for timer and async reset
module tb_ttt_move_arbiter;
    import ttt_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] buttons = '0;
    logic [8:0] occupied = '0;
    logic       start = 1'b0;
    logic       finished = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_player;
    logic       curr_player;
    logic       illegal_press;
    logic       turn_timeout;
    logic       new_game;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] btn;
        logic [8:0] occ;
        logic       st;
        logic       fin;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    ttt_move_arbiter #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .buttons       (buttons),
        .occupied      (occupied),
        .start         (start),
        .finished      (finished),
        .move_ready    (move_ready),
        .move_valid    (move_valid),
        .move_cell     (move_cell),
        .move_player   (move_player),
        .curr_player   (curr_player),
        .illegal_press (illegal_press),
        .turn_timeout  (turn_timeout),
        .new_game      (new_game)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {move_valid, move_cell, move_player, curr_player, illegal_press, turn_timeout, new_game};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [8:0] b, input logic [8:0] o, input logic s, input logic f, input logic r,
                       input logic v, input logic [3:0] c, input logic mp, input logic cp,
                       input logic il, input logic ng);
        vec_t x;
        x.btn = b; x.occ = o; x.st = s; x.fin = f; x.rdy = r;
        x.exp = {v, c, mp, cp, il, 1'b0, ng};
        vecs.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        bit seen;
        add(9'h000, 9'h000, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(9'h010, 9'h000, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(9'h010, 9'h000, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(9'h010, 9'h000, 0, 0, 1,  1, 4, 0, 0, 0, 0);
        add(9'h010, 9'h000, 0, 0, 1,  0, 4, 0, 1, 0, 0);
        add(9'h000, 9'h000, 0, 0, 1,  0, 4, 0, 1, 0, 0);
        add(9'h000, 9'h000, 0, 0, 0,  0, 4, 0, 1, 0, 0);
        add(9'h000, 9'h000, 0, 0, 0,  0, 4, 0, 1, 0, 0);
        add(9'h021, 9'h001, 0, 0, 0,  0, 4, 0, 1, 0, 0);
        add(9'h021, 9'h001, 0, 0, 0,  0, 4, 0, 1, 0, 0);
        add(9'h021, 9'h001, 0, 0, 1,  1, 5, 1, 1, 0, 0);
        add(9'h021, 9'h001, 0, 0, 1,  0, 5, 1, 0, 0, 0);
        add(9'h000, 9'h001, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h000, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h000, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h001, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h001, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h001, 9'h021, 0, 0, 0,  0, 5, 1, 0, 1, 0);
        add(9'h001, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h100, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h100, 9'h021, 0, 0, 0,  0, 5, 1, 0, 0, 0);
        add(9'h100, 9'h021, 0, 0, 0,  1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(9'h100, 9'h021, 0, 0, 0,  1, 8, 0, 0, 0, 0);
        add(9'h100, 9'h021, 0, 0, 1,  0, 8, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) add(9'h100, 9'h121, 0, 0, 1,  0, 8, 0, 1, 0, 0);
        add(9'h000, 9'h121, 0, 0, 0,  0, 8, 0, 1, 0, 0);
        add(9'h000, 9'h121, 0, 0, 0,  0, 8, 0, 1, 0, 0);
        add(9'h000, 9'h121, 0, 0, 0,  0, 8, 0, 1, 0, 0);
        add(9'h004, 9'h121, 0, 0, 0,  0, 8, 0, 1, 0, 0);
        add(9'h004, 9'h121, 0, 0, 0,  0, 8, 0, 1, 0, 0);
        add(9'h004, 9'h121, 0, 0, 0,  1, 2, 1, 1, 0, 0);
        add(9'h004, 9'h121, 0, 1, 1,  0, 2, 1, 0, 0, 1);
        add(9'h000, 9'h121, 0, 1, 0,  0, 2, 1, 0, 0, 0);
        add(9'h000, 9'h000, 0, 0, 0,  0, 2, 1, 0, 0, 0);
        add(9'h000, 9'h000, 1, 0, 0,  0, 2, 1, 0, 0, 0);
        add(9'h000, 9'h000, 0, 1, 0,  0, 2, 1, 0, 0, 1);
        add(9'h000, 9'h000, 0, 0, 0,  0, 2, 1, 0, 0, 0);

        tick();
        tick();
        check("reset_outputs", 32'(outs()), 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            buttons = vecs[i].btn;
            occupied = vecs[i].occ;
            start = vecs[i].st;
            finished = vecs[i].fin;
            move_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        check("idle_after_done", 32'(dut.state), 32'(IDLE));

        start = 1'b1;
        tick();
        start = 1'b0;
        check("armed_cp_clear", 32'(curr_player), 32'h0);
`ifdef TTT_TURN_TIMER_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("timer_quiet%0d", i), 32'(turn_timeout), 32'h0);
        end
        tick();
        check("timeout_pulse", 32'(turn_timeout), 32'h1);
        check("timeout_toggle", 32'(curr_player), 32'h1);
        tick();
        check("timeout_one_cycle", 32'(turn_timeout), 32'h0);
        finished = 1'b1;
        tick();
        finished = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_cp_clear", 32'(curr_player), 32'h0);
`else
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (turn_timeout) pulses++;
        end
        check("no_timeout_100", 32'(pulses), 32'h0);
        check("no_timeout_cp", 32'(curr_player), 32'h0);
`endif

        buttons = 9'h080;
        occupied = 9'h000;
        move_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = move_valid;
        end
        check("rst_valid_seen", 32'(seen), 32'h1);
        check("rst_cell", 32'(move_cell), 32'h7);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'h0);
        #3;
        reset_n = 1'b1;
        buttons = 9'h000;
        tick();
        check("post_reset_state", 32'(dut.state), 32'(IDLE));
        check("post_reset_valid", 32'(move_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
